// File: rtl/paicore_frame_scheduler.sv
// PAICORE transfer sequencer: forwards send_len frames round-robin over the
// enabled channels, then counts returned SNN frames until done or timed out.
module paicore_frame_scheduler #(
    parameter int All_Channel = 4,
    parameter int TIMEOUT_W   = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dp_rst_n,
    input  logic                   start,
    input  logic [31:0]            send_len,
    input  logic [31:0]            frame_num_max,
    input  logic [TIMEOUT_W-1:0]   timeout_cycles,
    input  logic                   single_channel,
    input  logic [All_Channel-1:0] single_channel_mask,
    input  logic [All_Channel-1:0] oen,
    input  logic                   s_valid,
    input  logic [63:0]            s_data,
    output logic                   s_ready,
    output logic [All_Channel-1:0] m_valid,
    output logic [63:0]            m_data,
    input  logic [All_Channel-1:0] m_ready,
    input  logic                   rx_frame,
    output logic                   busy,
    output logic                   tx_done,
    output logic                   rx_done,
    output logic                   timeout,
    output logic                   cfg_err,
    output logic [31:0]            sent_cnt,
    output logic [31:0]            rcvd_cnt
);

    localparam int GW = (All_Channel > 1) ? $clog2(All_Channel) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RECV,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [All_Channel-1:0] emask_q, emask_d;
    logic [31:0]            send_len_q, send_len_d;
    logic [31:0]            frame_max_q, frame_max_d;
    logic [TIMEOUT_W-1:0]   tmo_lim_q, tmo_lim_d;
    logic [TIMEOUT_W-1:0]   silence_q, silence_d;
    logic [31:0]            sent_cnt_q, sent_cnt_d;
    logic [31:0]            rcvd_cnt_q, rcvd_cnt_d;
    logic                   busy_q, busy_d;
    logic                   tx_done_q, tx_done_d;
    logic                   rx_done_q, rx_done_d;
    logic                   timeout_q, timeout_d;
    logic                   cfg_err_q, cfg_err_d;

    logic [All_Channel-1:0] eff_mask;
    logic                   handshake;
    logic [TIMEOUT_W-1:0]   silence_inc;

    function automatic logic [GW-1:0] lowest_set(input logic [All_Channel-1:0] mask);
        logic [GW-1:0] pick;
        pick = '0;
        for (int i = All_Channel - 1; i >= 0; i--) begin
            if (mask[i]) pick = i[GW-1:0];
        end
        return pick;
    endfunction

    // Scans upward from cur with wrap; the smallest offset wins, so a
    // single-bit mask leaves the grant where it is.
    function automatic logic [GW-1:0] next_set(input logic [All_Channel-1:0] mask,
                                               input logic [GW-1:0]          cur);
        logic [GW-1:0] pick;
        int            pos;
        pick = cur;
        for (int i = All_Channel - 1; i >= 1; i--) begin
            pos = (int'(cur) + i) % All_Channel;
            if (mask[pos[GW-1:0]]) pick = pos[GW-1:0];
        end
        return pick;
    endfunction

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        emask_d     = emask_q;
        send_len_d  = send_len_q;
        frame_max_d = frame_max_q;
        tmo_lim_d   = tmo_lim_q;
        silence_d   = silence_q;
        sent_cnt_d  = sent_cnt_q;
        rcvd_cnt_d  = rcvd_cnt_q;
        tx_done_d   = tx_done_q;
        rx_done_d   = rx_done_q;
        timeout_d   = timeout_q;
        cfg_err_d   = cfg_err_q;
        eff_mask    = single_channel ? single_channel_mask : oen;
        handshake   = (state_q == SEND) && s_valid && m_ready[grant_q];
        silence_inc = silence_q + TIMEOUT_W'(1);

        // The SNN may answer while frames are still going out.
        if ((state_q == SEND || state_q == RECV) && rx_frame && (rcvd_cnt_q != 32'hFFFF_FFFF))
            rcvd_cnt_d = rcvd_cnt_q + 32'd1;

        if (!dp_rst_n) begin
            state_d    = IDLE;
            grant_d    = '0;
            silence_d  = '0;
            sent_cnt_d = '0;
            rcvd_cnt_d = '0;
            tx_done_d  = 1'b0;
            rx_done_d  = 1'b0;
            timeout_d  = 1'b0;
            cfg_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        send_len_d  = send_len;
                        frame_max_d = frame_num_max;
                        tmo_lim_d   = timeout_cycles;
                        emask_d     = eff_mask;
                        grant_d     = lowest_set(eff_mask);
                        silence_d   = '0;
                        sent_cnt_d  = '0;
                        rcvd_cnt_d  = '0;
                        tx_done_d   = 1'b0;
                        rx_done_d   = 1'b0;
                        timeout_d   = 1'b0;
                        cfg_err_d   = 1'b0;
                        if (eff_mask == '0) begin
                            cfg_err_d = 1'b1;
                            state_d   = DONE;
                        end else if (send_len == 32'd0) begin
                            state_d = RECV;
                        end else begin
                            state_d = SEND;
                        end
                    end
                end
                SEND: begin
                    if (handshake) begin
                        sent_cnt_d = sent_cnt_q + 32'd1;
                        grant_d    = next_set(emask_q, grant_q);
                        if (sent_cnt_q == send_len_q - 32'd1) begin
                            tx_done_d = 1'b1;
                            silence_d = '0;
                            if (rcvd_cnt_d >= frame_max_q) begin
                                rx_done_d = 1'b1;
                                state_d   = DONE;
                            end else begin
                                state_d = RECV;
                            end
                        end
                    end
                end
                RECV: begin
                    // A frame arriving in the expiry cycle cancels the timeout.
                    if (rcvd_cnt_d >= frame_max_q) begin
                        rx_done_d = 1'b1;
                        state_d   = DONE;
                    end else if (rx_frame) begin
                        silence_d = '0;
                    end else if (tmo_lim_q != '0) begin
                        if (silence_inc == tmo_lim_q) begin
                            timeout_d = 1'b1;
                            state_d   = DONE;
                        end else begin
                            silence_d = silence_inc;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == SEND) || (state_d == RECV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            emask_q     <= '0;
            send_len_q  <= '0;
            frame_max_q <= '0;
            tmo_lim_q   <= '0;
            silence_q   <= '0;
            sent_cnt_q  <= '0;
            rcvd_cnt_q  <= '0;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_done_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            emask_q     <= emask_d;
            send_len_q  <= send_len_d;
            frame_max_q <= frame_max_d;
            tmo_lim_q   <= tmo_lim_d;
            silence_q   <= silence_d;
            sent_cnt_q  <= sent_cnt_d;
            rcvd_cnt_q  <= rcvd_cnt_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
            rx_done_q   <= rx_done_d;
            timeout_q   <= timeout_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_comb begin
        m_valid = '0;
        if (state_q == SEND) m_valid[grant_q] = s_valid;
    end

    assign s_ready  = (state_q == SEND) && m_ready[grant_q];
    assign m_data   = s_data;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;
    assign rx_done  = rx_done_q;
    assign timeout  = timeout_q;
    assign cfg_err  = cfg_err_q;
    assign sent_cnt = sent_cnt_q;
    assign rcvd_cnt = rcvd_cnt_q;

endmodule

// File: doc/paicore_frame_scheduler.md
# paicore_frame_scheduler

Sequences one PAICORE transfer: accepts a start command with frame counts and channel enables from the register file, forwards `send_len` 64-bit frames from the CPU-to-SNN FIFO to the enabled output channels in round-robin order, then counts returned SNN frames until `frame_num_max` arrive or a silence timeout expires. It sits between the AXI-Lite register file and the per-channel datapath. Its level status outputs drive the register file's `i_tx_done` / `i_rx_done` inputs.

## Interface
- `All_Channel`, 4, number of output channels.
- `TIMEOUT_W`, 24, width of the receive-silence timeout counter.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dp_rst_n`  in  1  synchronous soft reset from register (active low).
- `start`  in  1  single-cycle start command.
- `send_len`  in  32  frames to send.
- `frame_num_max`  in  32  frames expected back.
- `timeout_cycles`  in  TIMEOUT_W  silence limit in RECV; 0 = no timeout.
- `single_channel`  in  1  selects the single-channel mask.
- `single_channel_mask`  in  All_Channel  mask used when `single_channel`=1.
- `oen`  in  All_Channel  mask used when `single_channel`=0.
- `s_valid`  in  1  FIFO frame valid.
- `s_data`  in  64  FIFO frame data.
- `s_ready`  out  1  FIFO frame accept.
- `m_valid`  out  All_Channel  per-channel valid, one-hot or zero.
- `m_data`  out  64  shared channel data.
- `m_ready`  in  All_Channel  per-channel ready.
- `rx_frame`  in  1  one-cycle pulse per frame received from the SNN.
- `busy`  out  1  high in SEND or RECV.
- `tx_done`  out  1  level; all frames sent.
- `rx_done`  out  1  level; `frame_num_max` frames received.
- `timeout`  out  1  level; RECV aborted by timeout.
- `cfg_err`  out  1  level; start was issued with an effective mask of zero.
- `sent_cnt`, `rcvd_cnt`  out  32  live counters.

## Operation
- States: IDLE, SEND, RECV, DONE.
- **Start capture.** `start` is honoured only in IDLE; it is ignored in every other state. On start the block:
  - latches `send_len`, `frame_num_max`, `timeout_cycles`;
  - latches the effective mask `emask` = `single_channel` ? `single_channel_mask` : `oen`;
  - clears both counters and all four status flags.
- **Transition on start.**
  - `emask`==0 → DONE, with `cfg_err`=1.
  - Otherwise, `send_len`==0 → RECV.
  - Otherwise → SEND.
- **SEND datapath (combinational).**
  - `m_data`=`s_data`.
  - `m_valid`[g]=`s_valid`, where g is the current grant.
  - `s_ready`=`m_ready`[g].
  - Outside SEND, all `m_valid` and `s_ready` are 0.
- **Grant.**
  - Registered. At start it is loaded with the lowest set bit of `emask`.
  - On each handshake (`s_valid`&`s_ready`) it advances to the next set bit of `emask` above g, wrapping to the lowest.
  - A single-bit mask keeps g fixed.
- **End of SEND.** A handshake with `sent_cnt`==`send_len`-1 increments `sent_cnt` and sets `tx_done`. Next state is DONE if `rcvd_cnt`(next) ≥ `frame_num_max`, else RECV.
- **Receive counting.**
  - `rx_frame` increments `rcvd_cnt` in both SEND and RECV; the SNN may answer early.
  - `rcvd_cnt` saturates at 2^32-1.
  - `rx_frame` is ignored in IDLE and DONE.
- **RECV.**
  - `rcvd_cnt` reaching `frame_num_max` (including `frame_num_max`==0) → DONE, `rx_done`=1.
  - The silence counter clears on every `rx_frame`.
  - If `timeout_cycles`≠0 and the silence counter reaches `timeout_cycles` → DONE, `timeout`=1.
  - If `rx_frame` and expiry occur in the same cycle, the frame wins.
- **DONE.** Lasts exactly one cycle, then → IDLE. Status flags hold until the next accepted start, `dp_rst_n` low, or `rst_n` low.
- **Soft reset.** `dp_rst_n`=0 forces IDLE in any state and clears counters, grant and flags on the next edge. It takes priority over `start` and handshakes. A frame in flight is dropped: `s_ready`=0 from that edge.

## Timing
- **Reset values.** `rst_n` low asynchronously forces:
  - state=IDLE, grant=0;
  - all counters 0;
  - `busy`, `tx_done`, `rx_done`, `timeout`, `cfg_err` = 0;
  - `m_valid`=0, `s_ready`=0.
- **Start latency.**
  - `start` at edge N → SEND at N+1; `m_valid` can assert in cycle N+1.
  - `busy` is registered from state and rises at N+1.
- **Forwarding.** Zero latency: one frame per cycle when `s_valid` and the granted `m_ready` are continuously high.
- **Status flags.** `tx_done` rises on the edge after the final handshake. `rx_done` and `timeout` rise on the edge entering DONE.
- **Timeout.** With no `rx_frame`, `timeout` rises exactly `timeout_cycles` cycles after RECV entry.
- **Counters.** Arithmetic is 32-bit unsigned. Comparisons are made against the latched values, so input changes mid-transfer have no effect.

## Test plan
- **Round-robin.** `oen`=4'b1011, `send_len`=6, FIFO always valid, all ready → grants go 0,1,3,0,1,3; `tx_done` one cycle after the 6th handshake; `sent_cnt`=6.
- **Single channel with backpressure.** `single_channel`=1, mask=4'b0100, `send_len`=3, `m_ready`[2] toggling every cycle → only `m_valid`[2] is ever high; `s_ready` mirrors `m_ready`[2]; exactly 3 frames are transferred.
- **Early receive.** `send_len`=4, `frame_num_max`=2, two `rx_frame` pulses during SEND → direct SEND→DONE; `rx_done`=1 and `tx_done`=1 together; `rcvd_cnt`=2.
- **Timeout.** `send_len`=1, `frame_num_max`=5, `timeout_cycles`=10, one `rx_frame` at RECV+3, then silence → `timeout`=1 at RECV+14; `rx_done`=0; `rcvd_cnt`=1.
- **Config error and zero-length sends.**
  - mask 0 → `cfg_err`=1 with no `m_valid`.
  - `send_len`=0, `frame_num_max`=0 → IDLE→RECV→DONE with `rx_done`=1 and `tx_done`=0.
- **Reset mid-SEND.** `dp_rst_n` pulsed low after 2 of 8 frames → IDLE next edge; counters and flags 0. A following `start` behaves normally. Then `rst_n` asserted asynchronously mid-RECV → all outputs take their reset values immediately.
